fd_hazard_controller: RTL
=========================

// Module: fd_hazard_controller
// PURPOSE
//  Pipeline sequencer for the fetch/decode stage boundary. Drives the load enable of the
//  PC and of the F/D pipeline register, and the F/D flush. Inserts D/E bubbles and holds EX.
//  Resolves the following hazards: taken branches, load-use, instruction-memory wait
//  states and multi-cycle mul/div ops.
//  Sits beside the pipeline registers in the CPU top and is the only source of their enables.
// PARAMETERS
//  REG_ADDR_W     5    register-file address width
//  MULDIV_CYCLES  4    total EX cycles of a mul/div op (>=2)
//  WAIT_TIMEOUT   255  max consecutive imem wait cycles before fetch_timeout sets (>=1)
//  CNT_W          16   width of performance counters
// PORTS
//  clk              in   1           clock, rising edge
//  rst              in   1           asynchronous, active-low reset
//  imem_ready       in   1           fetch data valid this cycle
//  id_rs            in   REG_ADDR_W  source reg A of instruction in ID
//  id_rt            in   REG_ADDR_W  source reg B of instruction in ID
//  id_uses_rt       in   1           ID instruction reads id_rt
//  ex_mem_read      in   1           EX instruction is a load
//  ex_rd            in   REG_ADDR_W  EX destination reg
//  ex_branch_taken  in   1           EX resolved a taken branch/jump
//  ex_muldiv_start  in   1           mul/div op is in EX this cycle (first cycle)
//  pc_load_enable   out  1           PC loads next/target value
//  fd_load_enable   out  1           F/D register loads
//  fd_flush         out  1           F/D register loads NOP instead of fetched word
//  de_bubble        out  1           D/E register loads NOP
//  ex_hold          out  1           EX stage and D/E register hold
//  fetch_timeout    out  1           sticky error, imem wait exceeded WAIT_TIMEOUT
//  stall_cycles     out  CNT_W       cycles with pc_load_enable=0 (perf, see CONFIGURATION)
//  flush_count      out  CNT_W       taken-branch flushes (perf, see CONFIGURATION)
// BEHAVIOUR
//  State regs: FSM {RUN, IMEM_WAIT, MULDIV}, md_cnt, wait_cnt, fetch_timeout; async-cleared by rst=0.
//  Control outputs are combinational from state + inputs.
//  While rst=0: state=RUN, counters=0, fetch_timeout=0, pc/fd enables=0, fd_flush=0,
//   de_bubble=1, ex_hold=0.
//  Default (no hazard): pc_load_enable=fd_load_enable=1, others 0.
//  Priority each cycle: MULDIV state > ex_branch_taken > ex_muldiv_start > load-use > imem wait.
//  RUN:
//   - ex_branch_taken: pc_load=1, fd_load=1, fd_flush=1, de_bubble=1; stay RUN (penalty = 2 slots).
//   - ex_muldiv_start: pc_load=fd_load=0, ex_hold=1; md_cnt<=MULDIV_CYCLES-2; ->MULDIV.
//   - load-use: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | id_uses_rt&ex_rd==id_rt):
//     pc_load=fd_load=0, de_bubble=1, one cycle only, no state change.
//   - !imem_ready: pc_load=fd_load=0, de_bubble=1, wait_cnt<=1, ->IMEM_WAIT.
//  IMEM_WAIT: same outputs as the !imem_ready case while imem_ready=0; wait_cnt saturates at WAIT_TIMEOUT.
//   - wait_cnt==WAIT_TIMEOUT with imem_ready=0: fetch_timeout<=1 (sticky until reset).
//   - imem_ready=1: default outputs, wait_cnt<=0, ->RUN.
//   - ex_branch_taken in IMEM_WAIT overrides: redirect outputs as RUN; wait_cnt<=0; ->RUN
//     (fetch restarts at target).
//  MULDIV: pc_load=fd_load=0, ex_hold=1, de_bubble=0; branch/load-use inputs ignored.
//   - md_cnt decrements; at md_cnt==0 ex_hold drops this cycle, enables=1, ->RUN.
//   - Total stall = MULDIV_CYCLES-1 cycles.
//  fd_flush implies fd_load_enable=1. de_bubble and ex_hold are never both 1.
//  Reset mid-MULDIV/IMEM_WAIT aborts immediately; no pending redirect survives reset.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cycles increments on every non-reset cycle with pc_load_enable=0.
//   - flush_count increments on every fd_flush cycle. Both wrap at 2^CNT_W and are cleared by reset.
//  Not defined: no counter flops; stall_cycles and flush_count tied to 0.
// TESTING
//  1 Load-use: ex_mem_read=1, ex_rd=5, id_rs=5 for 1 cycle -> pc/fd enables 0, de_bubble=1, then default.
//  2 Load with ex_rd=0=id_rs, or id_rt match with id_uses_rt=0 -> no stall.
//  3 Branch: ex_branch_taken=1 while load-use also true -> fd_flush=1, de_bubble=1, pc_load=1.
//  4 MULDIV_CYCLES=4: ex_muldiv_start pulse -> ex_hold=1 for 3 cycles (incl. start) and 3 stall cycles;
//    branch asserted during this -> ignored.
//  5 imem_ready=0 for 256 cycles (WAIT_TIMEOUT=255) -> fetch_timeout=1 and stays 1 after ready returns;
//    ready after 3 cycles -> timeout stays 0.
//  6 rst=0 asynchronously mid-MULDIV -> outputs to reset values same cycle, RUN after release;
//    with HAZARD_PERF_CNT_EN, counters=0.

Source files
------------

// File: rtl/fd_hazard_controller.sv
// Fetch/decode hazard sequencer: PC/F-D enables, F-D flush, D-E bubble, EX hold.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module fd_hazard_controller #(
    parameter int REG_ADDR_W    = 5,
    parameter int MULDIV_CYCLES = 4,
    parameter int WAIT_TIMEOUT  = 255,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_ready,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  ex_muldiv_start,
    output logic                  pc_load_enable,
    output logic                  fd_load_enable,
    output logic                  fd_flush,
    output logic                  de_bubble,
    output logic                  ex_hold,
    output logic                  fetch_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int MD_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
    localparam int WT_W = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IMEM_WAIT = 2'd1,
        MULDIV    = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [MD_W-1:0] md_cnt, md_cnt_n;
    logic [WT_W-1:0] wait_cnt, wait_cnt_n;
    logic            timeout_n;
    logic            load_use;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            md_cnt        <= '0;
            wait_cnt      <= '0;
            fetch_timeout <= 1'b0;
        end else begin
            state         <= state_n;
            md_cnt        <= md_cnt_n;
            wait_cnt      <= wait_cnt_n;
            fetch_timeout <= timeout_n;
        end
    end

    always_comb begin
        pc_load_enable = 1'b1;
        fd_load_enable = 1'b1;
        fd_flush       = 1'b0;
        de_bubble      = 1'b0;
        ex_hold        = 1'b0;
        state_n        = state;
        md_cnt_n       = md_cnt;
        wait_cnt_n     = wait_cnt;
        timeout_n      = fetch_timeout;

        unique case (state)
            MULDIV: begin
                if (md_cnt == '0) begin
                    state_n = RUN;
                end else begin
                    pc_load_enable = 1'b0;
                    fd_load_enable = 1'b0;
                    ex_hold        = 1'b1;
                    md_cnt_n       = md_cnt - 1'b1;
                end
            end
            default: begin
                if (ex_branch_taken) begin
                    fd_flush   = 1'b1;
                    de_bubble  = 1'b1;
                    wait_cnt_n = '0;
                    state_n    = RUN;
                end else if (ex_muldiv_start) begin
                    pc_load_enable = 1'b0;
                    fd_load_enable = 1'b0;
                    ex_hold        = 1'b1;
                    md_cnt_n       = MD_W'(MULDIV_CYCLES - 2);
                    wait_cnt_n     = '0;
                    state_n        = MULDIV;
                end else begin
                    if (load_use || !imem_ready) begin
                        pc_load_enable = 1'b0;
                        fd_load_enable = 1'b0;
                        de_bubble      = 1'b1;
                    end
                    // wait tracking continues underneath a load-use stall
                    if (!imem_ready) begin
                        state_n = IMEM_WAIT;
                        if (state == RUN) begin
                            wait_cnt_n = WT_W'(1);
                        end else if (wait_cnt == WT_W'(WAIT_TIMEOUT)) begin
                            timeout_n = 1'b1;
                        end else begin
                            wait_cnt_n = wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt_n = '0;
                        state_n    = RUN;
                    end
                end
            end
        endcase

        if (!rst) begin
            pc_load_enable = 1'b0;
            fd_load_enable = 1'b0;
            fd_flush       = 1'b0;
            de_bubble      = 1'b1;
            ex_hold        = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_load_enable) stall_cycles <= stall_cycles + 1'b1;
            if (fd_flush)        flush_count  <= flush_count + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
